// File: rtl/bitrev_pkg.sv
// Shared constants for the round-robin bit-reverse scheduler: channel IDs,
// FSM encodings and default widths.
package bitrev_pkg;
  localparam logic       ID_A      = 1'b0;
  localparam logic       ID_B      = 1'b1;
  localparam logic [0:0] S_EMPTY   = 1'b0;
  localparam logic [0:0] S_FULL    = 1'b1;
  localparam int         DEF_WIDTH = 4;
  localparam int         DEF_CNT_W = 8;
endpackage

// File: rtl/bitrev_rr_sched_if.sv
// Handshake bundle for bitrev_rr_sched: two valid/ready request channels, the
// tagged result channel and debug counters; out_par only with BITREV_PARITY_EN.
interface bitrev_rr_sched_if
  import bitrev_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
`ifdef BITREV_PARITY_EN
  logic             out_par;
`endif

  modport master (
`ifdef BITREV_PARITY_EN
    input  out_par,
`endif
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_id, cnt_a, cnt_b
  );

  modport slave (
`ifdef BITREV_PARITY_EN
    output out_par,
`endif
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_id, cnt_a, cnt_b
  );
endinterface

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal: out_o[i] = in_i[WIDTH-1-i]; zero latency.
module bit_reverse #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);
  always_comb begin
    out_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_o[i] = in_i[WIDTH-1-i];
    end
  end
endmodule

// File: rtl/bitrev_rr_sched.sv
// Round-robin arbiter sharing one bit-reverse path between A and B; 1-cycle latency,
// readies drop when the result register is held; BITREV_PARITY_EN adds out_par.
module bitrev_rr_sched
  import bitrev_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  bitrev_rr_sched_if.slave   bus
);
  logic [0:0]       state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             can_accept, grant_a, grant_b, fire_a, fire_b;
  logic [WIDTH-1:0] sel_data, rev_data;

  always_comb begin
    can_accept = (state_q == S_EMPTY) | bus.out_ready;
    // On contention the channel that was not served last wins.
    grant_a    = bus.a_valid & (~bus.b_valid | (last_id_q == ID_B));
    grant_b    = bus.b_valid & (~bus.a_valid | (last_id_q == ID_A));
    fire_a     = ~rst & can_accept & grant_a;
    fire_b     = ~rst & can_accept & grant_b;
    sel_data   = grant_b ? bus.b_data : bus.a_data;
  end

  bit_reverse #(.WIDTH(WIDTH)) u_rev (
    .in_i  (sel_data),
    .out_o (rev_data)
  );

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    data_d    = data_q;
    id_d      = id_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    if (fire_a | fire_b) begin
      state_d   = S_FULL;
      data_d    = rev_data;
      id_d      = fire_b ? ID_B : ID_A;
      last_id_d = fire_b ? ID_B : ID_A;
      if (fire_a && !(&cnt_a_q)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (fire_b && !(&cnt_b_q)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end else if ((state_q == S_FULL) && bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      last_id_q <= ID_B;
      data_q    <= '0;
      id_q      <= ID_A;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      data_q    <= data_d;
      id_q      <= id_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

`ifdef BITREV_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (fire_a | fire_b) par_d = ^rev_data;
  end

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign bus.out_par = par_q;
`endif

  assign bus.a_ready   = fire_a;
  assign bus.b_ready   = fire_b;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;
endmodule

// File: tb/tb_bitrev_rr_sched.sv
// Bench for bitrev_rr_sched: vector table plus corner-case sequences, with a
// result scoreboard; a second instance with CNT_W=2 exercises saturation.
module tb_bitrev_rr_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] a_data = '0, b_data = '0;
  int         total = 0, bad = 0, pops = 0;
  logic [4:0] sb[$];
  logic [4:0] e;

  always #5 clk = ~clk;

  bitrev_rr_sched_if #(.WIDTH(4), .CNT_W(8)) bus ();
  bitrev_rr_sched_if #(.WIDTH(4), .CNT_W(2)) sbus ();

  assign bus.a_valid    = a_valid;
  assign bus.a_data     = a_data;
  assign bus.b_valid    = b_valid;
  assign bus.b_data     = b_data;
  assign bus.out_ready  = out_ready;
  assign sbus.a_valid   = a_valid;
  assign sbus.a_data    = a_data;
  assign sbus.b_valid   = b_valid;
  assign sbus.b_data    = b_data;
  assign sbus.out_ready = out_ready;

  bitrev_rr_sched #(.WIDTH(4), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  bitrev_rr_sched #(.WIDTH(4), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic bv,
                       input logic [3:0] bd, input logic ordy);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
  endtask

  // Scoreboard: pop on output handshake, then push on input handshakes.
  always @(negedge clk) begin
    if (bus.out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got result %0h expected none", bus.out_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(e[3:0]));
        check("sb_id", 32'(bus.out_id), 32'(e[4]));
        pops++;
      end
    end
`ifdef BITREV_PARITY_EN
    if (bus.out_valid) check("par_track", 32'(bus.out_par), 32'(^bus.out_data));
`endif
    if (rst) sb.delete();
    else begin
      if (a_valid && bus.a_ready) sb.push_back({1'b0, rev4(a_data)});
      if (b_valid && bus.b_ready) sb.push_back({1'b1, rev4(b_data)});
    end
  end

  typedef struct {
    logic av; logic [3:0] ad; logic bv; logic [3:0] bd; logic ordy;
    logic ar; logic br; logic ov; logic [3:0] od; logic oid;
  } vec_t;
  vec_t vt[17];

  initial begin
    //         av    ad       bv    bd       ordy  ar    br    ov    od       oid
    vt[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0};
    vt[2]  = '{1'b1, 4'b0011, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
    vt[3]  = '{1'b1, 4'b0011, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1};
    vt[4]  = '{1'b1, 4'b0011, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0};
    vt[5]  = '{1'b1, 4'b0011, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1};
    vt[6]  = '{1'b1, 4'b0011, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1};
    vt[7]  = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1};
    vt[8]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0};
    vt[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1};
    vt[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1};
    vt[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[12] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
    vt[13] = '{1'b0, 4'b0000, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0};
    vt[14] = '{1'b0, 4'b0000, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0};
    vt[15] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b1};
    vt[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};

    tick();
    // Reset state, with both requesters asserting valid during reset.
    drive(1'b1, 4'b0001, 1'b1, 4'b0010, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_a_ready", 32'(bus.a_ready), 32'(0));
    check("rst_b_ready", 32'(bus.b_ready), 32'(0));
    tick();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    check("rst_out_id", 32'(bus.out_id), 32'(0));
    check("rst_cnt_a", 32'(bus.cnt_a), 32'(0));
    check("rst_cnt_b", 32'(bus.cnt_b), 32'(0));

    // Vector table, starting from fresh reset.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].av, vt[i].ad, vt[i].bv, vt[i].bd, vt[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_a_ready", i), 32'(bus.a_ready), 32'(vt[i].ar));
      check($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready), 32'(vt[i].br));
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      if (vt[i].ov) begin
        check($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].od));
        check($sformatf("vec%0d_out_id", i), 32'(bus.out_id), 32'(vt[i].oid));
      end
      if (i == 1) check("vec_cnt_a_first", 32'(bus.cnt_a), 32'(1));
      tick();
    end
    check("vec_cnt_a", 32'(bus.cnt_a), 32'(4));
    check("vec_cnt_b", 32'(bus.cnt_b), 32'(4));

    // Contention straight after reset: A first, then strict alternation.
    do_reset();
    drive(1'b1, 4'b0011, 1'b1, 4'b0110, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("alt%0d_valid", k), 32'(bus.out_valid), 32'(1));
      check($sformatf("alt%0d_id", k), 32'(bus.out_id), 32'(k % 2));
      check($sformatf("alt%0d_data", k), 32'(bus.out_data), (k % 2 == 0) ? 32'(4'b1100) : 32'(4'b0110));
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();

    // Stall for 5 cycles, then drain with a same-cycle new grant.
    do_reset();
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_a_ready", k), 32'(bus.a_ready), 32'(0));
      check($sformatf("stall%0d_b_ready", k), 32'(bus.b_ready), 32'(0));
      check($sformatf("stall%0d_data", k), 32'(bus.out_data), 32'(4'b1000));
      check($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'(1));
      tick();
    end
    drive(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check("drain_a_ready", 32'(bus.a_ready), 32'(1));
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 32'(1));
    check("drain_data", 32'(bus.out_data), 32'(4'b0100));
    tick();

    // Idle cycles must not rotate priority.
    do_reset();
    drive(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    repeat (3) tick();
    drive(1'b1, 4'b0101, 1'b1, 4'b1001, 1'b1);
    @(negedge clk);
    check("prio_a_ready", 32'(bus.a_ready), 32'(1));
    check("prio_b_ready", 32'(bus.b_ready), 32'(0));
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();

    // Counter saturation on the CNT_W=2 instance.
    do_reset();
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'(k + 1), 1'b0, 4'b0000, 1'b1);
      tick();
      check($sformatf("sat%0d_cnt_a", k), 32'(sbus.cnt_a), 32'((k + 1 > 3) ? 3 : k + 1));
      check($sformatf("wide%0d_cnt_a", k), 32'(bus.cnt_a), 32'(k + 1));
    end
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick();
    check("sat_results_delivered", 32'(pops), 32'(5));

    // Reset in the middle of a stall drops the held result.
    do_reset();
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    do_reset();
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.out_valid), 32'(0));
    check("rst_mid_cnt_a", 32'(bus.cnt_a), 32'(0));
    check("rst_mid_cnt_b", 32'(bus.cnt_b), 32'(0));
    tick();
    drive(1'b1, 4'b1101, 1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    check("rst_mid_a_first", 32'(bus.a_ready), 32'(1));
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check("rst_mid_data", 32'(bus.out_data), 32'(4'b1011));
`ifdef BITREV_PARITY_EN
    check("rst_mid_par", 32'(bus.out_par), 32'(1));
`endif
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bitrev_rr_sched.md
Name: bitrev_rr_sched

Overview:
- Shares one bit-reverse datapath between two requesters, A and B.
- Arbitration is round-robin.
- Each input channel has a valid/ready handshake. Results go to a single registered output, tagged with the source ID.
- Sits between two producer blocks and one downstream consumer. It also keeps saturating per-channel service counters for debug.

Parameters:
- WIDTH, 4, data width of each request and result (≥2).
- CNT_W, 8, width of each per-channel service counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has data.
- a_data  input  WIDTH  requester A operand.
- a_ready  output  1  A's transfer completes this cycle when a_valid & a_ready.
- b_valid  input  1  requester B has data.
- b_data  input  WIDTH  requester B operand.
- b_ready  output  1  B's transfer completes this cycle when b_valid & b_ready.
- out_valid  output  1  result register holds a valid result.
- out_data  output  WIDTH  bit-reversed operand: out_data[i] = operand[WIDTH-1-i].
- out_id  output  1  source of the result: 0 = A, 1 = B.
- out_ready  input  1  consumer accepts the result when out_valid & out_ready.
- cnt_a  output  CNT_W  count of accepted A transfers; saturates at all-ones.
- cnt_b  output  CNT_W  count of accepted B transfers; saturates at all-ones.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_id=0, cnt_a=0, cnt_b=0.
  - Internal last_id=1, so A has priority on the first contention.
  - State = EMPTY.
- FSM states: EMPTY (result register empty) and FULL (result held).
  - EMPTY -> FULL when a grant fires.
  - FULL -> EMPTY when out_ready=1 and no new grant fires.
  - FULL -> FULL when out_ready=1 and a grant fires (back-to-back), or when out_ready=0 (stall).
  - out_valid == (state==FULL).
- Slot free: can_accept = (state==EMPTY) | out_ready.
- Grant selection (combinational):
  - Only A valid -> A.
  - Only B valid -> B.
  - Both valid -> the channel != last_id.
  - a_ready = can_accept & grant_A; b_ready = can_accept & grant_B.
  - At most one ready is high per cycle.
  - Ready may depend on valid. Valid must not depend on ready.
- On a transfer:
  - Next edge loads out_data = bitrev(selected data) and out_id = selected channel.
  - last_id <= selected channel.
  - The matching counter increments unless it is all-ones.
- Latency: 1 cycle from input handshake to out_valid.
  - Throughput is 1 result/cycle with out_ready held high.
- Stall (FULL & !out_ready): out_data and out_id are held stable; both readies are 0.
- last_id changes only on a transfer. Idle cycles do not rotate priority.
- Reset mid-operation drops any held result: out_valid=0 on the next edge, counters cleared, no handshake in the reset cycle.
  - a_ready and b_ready are forced to 0 while rst=1.
- Counter saturation: at all-ones, further transfers are still accepted; the counter stays at all-ones.

Optional Feature:
- Macro: BITREV_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = XOR-reduction of out_data, registered with out_data.
  - Reset value 0; held during stall.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package bitrev_pkg:
  - ID_A = 1'b0, ID_B = 1'b1.
  - State encoding S_EMPTY = 1'b0, S_FULL = 1'b1.
  - Default WIDTH 4.
- Sub-module bit_reverse (parameter WIDTH; combinational in -> out, out[i] = in[WIDTH-1-i]):
  - Instantiated once on the muxed operand, so the datapath is genuinely shared.

Test Plan:
- Reset then single A: a_data=4'b0001 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=4'b1000, out_id=0; cnt_a=1.
- Contention after reset: A=4'b0011, B=4'b0110 both held valid, out_ready=1 -> results alternate every cycle:
  - A 4'b1100 (id 0), B 4'b0110 (id 1), A, B, ...
- Stall: out_ready=0 with a result held, a_valid=1 -> a_ready=b_ready=0; out_data stable for 5 cycles. Raise out_ready -> result drains and a new A grant fires the same cycle; out_valid stays 1.
- Priority persistence: B alone served, 3 idle cycles, then A and B together -> A granted first (last_id=B unchanged by idle).
- Saturation: CNT_W=2, 5 consecutive A transfers -> cnt_a sequence 1,2,3,3,3; all 5 results delivered.
- Reset mid-stall: FULL with out_ready=0, pulse rst for 1 cycle -> out_valid=0, cnt_a=cnt_b=0; the next contention grants A first. With BITREV_PARITY_EN, out_data=4'b1011 gives out_par=1.
